// File: rtl/mem_access_pkg.sv
// Shared constants and state encoding for the memory access sequencer.
package mem_access_pkg;

  // Geometry of the 16x8 synchronous memory this unit fronts.
  localparam int MEM_ADDR_W = 4;
  localparam int MEM_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Memory access sequencer: accepts one read/write request, drives the
// synchronous memory from MAR/MBR, and returns one response per request.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_mar;
  logic [DATA_W-1:0]   r_mbr;
  logic                r_wflag;
  logic                w_accept;

  assign w_accept = (r_state == ST_IDLE) && req_valid;

  // Next-state decode; RESP never hands straight to a new request.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (req_valid) w_next = req_write ? ST_WRITE : ST_READ;
      ST_WRITE:   w_next = ST_RESP;
      ST_READ:    w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_RESP;
      ST_RESP:    if (rsp_ready) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // MAR/MBR/WFLAG: latch on acceptance, MBR reloads from memory in CAPTURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mar   <= '0;
      r_mbr   <= '0;
      r_wflag <= 1'b0;
    end else if (w_accept) begin
      r_mar   <= req_addr;
      r_mbr   <= req_wdata;
      r_wflag <= req_write;
    end else if (r_state == ST_CAPTURE) begin
      r_mbr   <= mem_data_out;
    end
  end

  // Outputs are pure state decode so reset clears them without an edge.
  assign req_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign mem_we      = (r_state == ST_WRITE);
  assign rsp_valid   = (r_state == ST_RESP);
  assign rsp_write   = rsp_valid & r_wflag;
  assign rsp_rdata   = rsp_valid ? r_mbr : '0;
  assign mem_address = r_mar;
  assign mem_data_in = r_mbr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit with a behavioural 16x8 registered-read memory
// and a transaction-level reference model compared every negedge.
module tb_mem_access_unit;

  logic       clk;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready, rsp_write;
  logic [7:0] rsp_rdata;
  logic       mem_we;
  logic [3:0] mem_address;
  logic [7:0] mem_data_in, mem_data_out;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  mem_access_unit #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .mem_we(mem_we), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: write on we, registered read of the current address.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (mem_we) mem[mem_address] <= mem_data_in;
    mem_data_out <= mem[mem_address];
  end

  // Transaction-level reference: one outstanding request, its age in edges,
  // and the data it carries. Memory image updated when the write lands.
  logic       m_started = 1'b0;
  logic       m_pend, m_rsp, m_write, m_age;
  logic [3:0] m_addr;
  logic [7:0] m_data;
  logic [7:0] m_mem [16];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_started <= 1'b1;
      m_pend <= 1'b0; m_rsp <= 1'b0; m_write <= 1'b0; m_age <= 1'b0;
      m_addr <= 4'h0; m_data <= 8'h00;
    end else if (!m_pend) begin
      if (req_valid) begin
        m_pend <= 1'b1; m_rsp <= 1'b0; m_age <= 1'b0;
        m_write <= req_write; m_addr <= req_addr; m_data <= req_wdata;
      end
    end else if (m_rsp) begin
      if (rsp_ready) begin m_pend <= 1'b0; m_rsp <= 1'b0; end
    end else if (m_write) begin
      m_mem[m_addr] <= m_data;
      m_rsp <= 1'b1;
    end else if (!m_age) begin
      m_age <= 1'b1;
    end else begin
      m_data <= m_mem[m_addr];
      m_rsp  <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  // Compare process: DUT outputs against the model away from the clock edge.
  always @(negedge clk) begin
    if (m_started) begin
      chk("req_ready",   req_ready,   !m_pend);
      chk("busy",        busy,        m_pend);
      chk("rsp_valid",   rsp_valid,   m_rsp);
      chk("mem_we",      mem_we,      m_pend && m_write && !m_rsp);
      chk("mem_address", mem_address, m_addr);
      chk("mem_data_in", mem_data_in, m_data);
      if (m_rsp) begin
        chk("rsp_write", rsp_write, m_write);
        chk("rsp_rdata", rsp_rdata, m_data);
      end
    end
  end

  // Acceptance log for throughput measurement.
  int cyc = 0;
  int acc_q[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && req_valid && req_ready) acc_q.push_back(cyc);
  end

  // One full request/response with rsp_ready held high; edges counts
  // clock edges from acceptance to the first cycle rsp_valid is seen.
  task automatic xact(input logic w, input logic [3:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic rw, output int edges);
    int  n;
    logic ok;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 10) begin
      ok = req_ready;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    rd = 8'h00; rw = 1'b0; edges = 0;
    if (!ok) begin tmo("accept"); return; end
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!rsp_valid && edges < 10);
    if (!rsp_valid) tmo("response");
    rd = rsp_rdata; rw = rsp_write;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] rd;
    logic       rw;
    int         ed;
    int         n;

    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0;
    req_wdata = 8'h00; rsp_ready = 1'b0;

    // Asynchronous reset between edges: outputs settle with no clock.
    #2 rst = 1'b1;
    #1;
    chk("rst_req_ready",   req_ready,   1);
    chk("rst_busy",        busy,        0);
    chk("rst_rsp_valid",   rsp_valid,   0);
    chk("rst_rsp_write",   rsp_write,   0);
    chk("rst_rsp_rdata",   rsp_rdata,   0);
    chk("rst_mem_we",      mem_we,      0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data_in", mem_data_in, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Write then read the same address.
    xact(1'b1, 4'h3, 8'hA5, rd, rw, ed);
    chk("wr_rdata", rd, 8'hA5);
    chk("wr_rspw",  rw, 1);
    chk("wr_lat",   ed, 1);
    xact(1'b0, 4'h3, 8'h00, rd, rw, ed);
    chk("rd_rdata", rd, 8'hA5);
    chk("rd_rspw",  rw, 0);
    chk("rd_lat",   ed, 2);

    // Full sweep, then read back including the F -> 0 wrap.
    for (int a = 0; a < 16; a++) begin
      xact(1'b1, 4'(a), 8'(a * 8'h11), rd, rw, ed);
      chk("sweep_wr", rd, 8'(a * 8'h11));
    end
    for (int a = 0; a < 17; a++) begin
      xact(1'b0, 4'(a % 16), 8'h00, rd, rw, ed);
      chk("sweep_rd", rd, 8'((a % 16) * 8'h11));
    end

    // Response backpressure on a read of 0x7.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h7; req_wdata = 8'h00;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) tmo("bp_response");
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h0; req_wdata = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, 8'h77);
      chk("bp_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", req_ready, 1);
    xact(1'b0, 4'h0, 8'h00, rd, rw, ed);
    chk("bp_ignored_wr", rd, 8'h00);

    // Reset during WRITE before the landing edge aborts the write.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h9; req_wdata = 8'h3C;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mw_we_before", mem_we, 1);
    #2 rst = 1'b1;
    #1;
    chk("mw_we_dropped", mem_we, 0);
    chk("mw_busy",       busy,   0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mw_no_rsp", rsp_valid, 0);
    end
    xact(1'b0, 4'h9, 8'h00, rd, rw, ed);
    chk("mw_prior", rd, 8'h99);

    // Back-to-back writes: one acceptance every 3 cycles.
    acc_q.delete();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'hA; req_wdata = 8'h5A;
    rsp_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("tp_wr_count", acc_q.size(), 4);
    for (int i = 1; i < acc_q.size(); i++) chk("tp_wr_gap", acc_q[i] - acc_q[i-1], 3);

    // Back-to-back reads: one acceptance every 4 cycles.
    acc_q.delete();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'hA;
    repeat (16) @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("tp_rd_count", acc_q.size(), 4);
    for (int i = 1; i < acc_q.size(); i++) chk("tp_rd_gap", acc_q[i] - acc_q[i-1], 4);
    xact(1'b0, 4'hA, 8'h00, rd, rw, ed);
    chk("tp_rd_data", rd, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
